// File: rtl/fcvt_issue_ctrl_pkg.sv
// Shared constants for the ftoi issue controller: pipeline latency, default
// tag width and the packed {data, tag, src} result-entry width.
package fcvt_issue_ctrl_pkg;

  localparam int FTOI_LAT  = 2;
  localparam int TAG_W_DEF = 4;

  function automatic int entry_w(input int tag_w);
    return 32 + tag_w + 1;
  endfunction

  localparam int ENTRY_W_DEF = entry_w(TAG_W_DEF);

endpackage

// File: rtl/fcvt_issue_ctrl_ftoi.sv
// Fixed-latency, non-stallable float32 -> int32 converter (two register stages).
// Rounds half away from zero; biased exponents below 126 or above 157 give 0.
module fcvt_issue_ctrl_ftoi
  import fcvt_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op,
  output logic [31:0] result
);

  logic [31:0] s1_op;
  logic [31:0] s2_res;
  logic [31:0] conv;
  logic [7:0]  exp_f;
  logic [31:0] m32;
  logic [4:0]  rsh;
  logic [4:0]  rb_idx;
  logic [2:0]  lsh;
  logic [31:0] mag;

  always_comb begin
    exp_f  = s1_op[30:23];
    m32    = {8'd0, 1'b1, s1_op[22:0]};
    rsh    = 5'(8'd150 - exp_f);
    rb_idx = rsh - 5'd1;
    lsh    = 3'(exp_f - 8'd150);
    mag    = '0;
    conv   = '0;
    if (exp_f >= 8'd126 && exp_f <= 8'd157) begin
      // The bit just below the integer point decides round-up on the magnitude.
      if (exp_f >= 8'd150) mag = m32 << lsh;
      else                 mag = (m32 >> rsh) + {31'd0, m32[rb_idx]};
      conv = s1_op[31] ? (~mag + 32'd1) : mag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_op  <= '0;
      s2_res <= '0;
    end else begin
      s1_op  <= op;
      s2_res <= conv;
    end
  end

  assign result = s2_res;

endmodule

// File: rtl/fcvt_issue_ctrl.sv
// Round-robin issue controller for the shared ftoi pipeline, with shadow
// tag/source tracking and a credit-protected result FIFO.
module fcvt_issue_ctrl
  import fcvt_issue_ctrl_pkg::*;
#(
  parameter int TAG_W      = TAG_W_DEF,
  parameter int FIFO_DEPTH = 4
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [31:0]      req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_src,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int ENTRY_W = entry_w(TAG_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Handshakes: a transfer happens in any cycle where valid && ready are both
  // high. Request ready is combinational from credit and arbitration; response
  // valid comes only from registered FIFO state, and ready never gates valid.

  logic                last;
  logic                gnt;
  logic                credit_ok;
  logic                accept;
  logic [CNT_W:0]      credit_used;
  logic [31:0]         issue_op;
  logic [TAG_W:0]      issue_meta;
  logic [31:0]         ftoi_res;

  logic [FTOI_LAT-1:0] sh_v;
  logic [TAG_W:0]      sh_meta [FTOI_LAT];

  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                push;
  logic                pop;

  // Credit counts buffered plus in-flight entries; a same-cycle pop is not credited.
  always_comb begin
    credit_used = (CNT_W + 1)'(count);
    for (int i = 0; i < FTOI_LAT; i++) credit_used = credit_used + (CNT_W + 1)'(sh_v[i]);
    credit_ok = reset && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  end

  always_comb begin
    gnt = ~last;
    if (req0_valid && !req1_valid)      gnt = 1'b0;
    else if (req1_valid && !req0_valid) gnt = 1'b1;
    req0_ready = credit_ok & ~gnt;
    req1_ready = credit_ok & gnt;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    issue_op   = gnt ? req1_op : req0_op;
    issue_meta = gnt ? {req1_tag, 1'b1} : {req0_tag, 1'b0};
  end

  fcvt_issue_ctrl_ftoi u_ftoi (
    .clk    (clk),
    .reset  (reset),
    .op     (issue_op),
    .result (ftoi_res)
  );

  assign push      = sh_v[FTOI_LAT-1];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = (|sh_v) | rsp_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last   <= 1'b1;
      sh_v   <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) last <= gnt;
      sh_v <= {sh_v[FTOI_LAT-2:0], accept};
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Shadow metadata and FIFO storage need no reset: the valid bits and count qualify them.
  always_ff @(posedge clk) begin
    sh_meta[0] <= issue_meta;
    for (int i = 1; i < FTOI_LAT; i++) sh_meta[i] <= sh_meta[i-1];
    if (push) mem[wr_ptr] <= {ftoi_res, sh_meta[FTOI_LAT-1]};
  end

  assign {rsp_data, rsp_tag, rsp_src} = mem[rd_ptr];

endmodule

// File: tb/tb_fcvt_issue_ctrl.sv
// Self-checking bench for fcvt_issue_ctrl: behavioural model of credit,
// round-robin grant and conversion, with an ordered expected-result queue.
module tb_fcvt_issue_ctrl;

  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int EW    = 32 + TAG_W + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_op, req1_op;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             req0_ready, req1_ready;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_src;
  logic             rsp_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  logic          m_last;

  fcvt_issue_ctrl #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_tag   (req0_tag),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_tag   (req1_tag),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_src    (rsp_src),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference conversion from the numeric value: |x| rounded half up, sign reapplied.
  function automatic logic [31:0] ref_ftoi(input logic [31:0] f);
    int  e;
    real mag;
    int  r;
    e = int'(f[30:23]);
    if (e < 126 || e > 157) return 32'd0;
    mag = real'({1'b1, f[22:0]});
    for (int i = 0; i < e - 150; i++) mag = mag * 2.0;
    for (int i = 0; i < 150 - e; i++) mag = mag / 2.0;
    r = $rtoi(mag + 0.5);
    return f[31] ? 32'(-r) : 32'(r);
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    case ($urandom_range(0, 9))
      0:       e = 8'd255;
      1:       e = 8'($urandom_range(0, 125));
      default: e = 8'($urandom_range(124, 159));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic g1, e_r0, e_r1, e_valid, credit;
    if (!reset) begin
      check("reset_outs", {60'd0, req0_ready, req1_ready, rsp_valid, busy}, 64'd0);
      exp_q.delete();
      due_q.delete();
      m_last = 1'b1;
    end else begin
      credit = exp_q.size() < DEPTH;
      g1 = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e_r0 = credit && !g1;
      e_r1 = credit && g1;
      if (req0_valid || req1_valid) begin
        check("req0_ready", {63'd0, req0_ready}, {63'd0, e_r0});
        check("req1_ready", {63'd0, req1_ready}, {63'd0, e_r1});
      end
      e_valid = (due_q.size() > 0) && (due_q[0] <= cyc);
      check("rsp_valid", {63'd0, rsp_valid}, {63'd0, e_valid});
      check("busy", {63'd0, busy}, {63'd0, exp_q.size() != 0});
      if (e_valid && rsp_ready) begin
        check("rsp_entry", {27'd0, rsp_data, rsp_tag, rsp_src}, {27'd0, exp_q[0]});
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (req0_valid && e_r0) begin
        exp_q.push_back({ref_ftoi(req0_op), req0_tag, 1'b0});
        due_q.push_back(cyc + 3);
        m_last = 1'b0;
      end else if (req1_valid && e_r1) begin
        exp_q.push_back({ref_ftoi(req1_op), req1_tag, 1'b1});
        due_q.push_back(cyc + 3);
        m_last = 1'b1;
      end
    end
    cyc++;
  end

  // driver: apply one cycle of inputs, then advance to just past the next edge
  task automatic drive(input logic v0, input logic [31:0] o0, input logic [TAG_W-1:0] t0,
                       input logic v1, input logic [31:0] o1, input logic [TAG_W-1:0] t1,
                       input logic rr);
    req0_valid = v0; req0_op = o0; req0_tag = t0;
    req1_valid = v1; req1_op = o1; req1_tag = t1;
    rsp_ready  = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, '0, 1'b0, 32'd0, '0, rr);
  endtask

  initial begin
    logic [31:0] edge_ops [3];
    edge_ops[0] = 32'h3E800000;
    edge_ops[1] = 32'h3F000000;
    edge_ops[2] = 32'h4F000000;
    reset = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = '0; req1_tag = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // single op
    drive(1'b1, 32'h3FC00000, 4'd5, 1'b0, 32'd0, '0, 1'b1);
    idle(5, 1'b1);

    // contention: alternating grants, one response per cycle
    for (int i = 0; i < 12; i++)
      drive(1'b1, 32'h3F800000, 4'(i), 1'b1, 32'hC0200000, 4'(i + 8), 1'b1);
    idle(5, 1'b1);

    // back-pressure then drain, with streaming continuing into the drain
    for (int i = 0; i < 8; i++) drive(1'b1, rand_op(), 4'(i), 1'b0, 32'd0, '0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, rand_op(), 4'(i), 1'b0, 32'd0, '0, 1'b1);
    idle(6, 1'b1);

    // range edges
    for (int i = 0; i < 3; i++) drive(1'b1, edge_ops[i], 4'(i), 1'b0, 32'd0, '0, 1'b1);
    idle(5, 1'b1);

    // mid-flight reset: 2 buffered, 2 in flight
    for (int i = 0; i < 4; i++) drive(1'b1, rand_op(), 4'(i), 1'b0, 32'd0, '0, 1'b0);
    reset = 1'b0;
    idle(2, 1'b1);
    reset = 1'b1;
    drive(1'b1, 32'h40400000, 4'd1, 1'b1, 32'h40800000, 4'd2, 1'b1);
    idle(5, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), rand_op(), 4'($urandom),
            1'($urandom_range(0, 1)), rand_op(), 4'($urandom),
            $urandom_range(0, 3) != 0);

    idle(12, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fcvt_issue_ctrl.md
# fcvt_issue_ctrl

Issue controller for the shared float-to-int conversion pipeline (`ftoi`). It arbitrates round-robin between two requesters, each of which presents a 32-bit single-precision operand and a tag. It tracks in-flight operations alongside the fixed-latency, non-stallable `ftoi` datapath and buffers results in a credit-protected FIFO, so that back-pressure on the response side never drops a result.

## Interface
Parameters:
- `TAG_W`, default 4: width of the requester tag carried with each operation.
- `FIFO_DEPTH`, default 4: number of result FIFO entries; also the total credit count (FIFO entries plus in-flight operations).

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low.
- `req0_valid`, in, 1: port 0 has an operation.
- `req0_op`, in, 32: IEEE-754 single operand.
- `req0_tag`, in, `TAG_W`: requester tag.
- `req0_ready`, out, 1: port 0 operation accepted this cycle.
- `req1_valid` / `req1_op` / `req1_tag` / `req1_ready`: same as port 0, for port 1.
- `rsp_valid`, out, 1: FIFO head is valid.
- `rsp_data`, out, 32: signed int32 result.
- `rsp_tag`, out, `TAG_W`: tag of the head entry.
- `rsp_src`, out, 1: originating port, 0 or 1.
- `rsp_ready`, in, 1: consumer pops the head.
- `busy`, out, 1: any operation is in flight or buffered.

## Operation
- **Credit:** issue is allowed when `count + s1_v + s2_v < FIFO_DEPTH`.
  - `count` is FIFO occupancy.
  - `s1_v` / `s2_v` are the shadow valid bits for the 2 `ftoi` stages.
  - A same-cycle pop is not credited.
- **Arbiter:**
  - `last` pointer.
  - If both ports are valid, grant the port not equal to `last`; if only one is valid, grant it.
  - `last` updates only when an accept occurs.
  - Reset value of `last` is 1, so port 0 wins first.
- **Ready:** `reqN_ready` = credit ok AND grant to N (combinational; does not depend on `reqN_valid` of the other port beyond arbitration).
- **Accept:** an operation is accepted when `reqN_valid && reqN_ready`.
  - The muxed op drives the `ftoi` input.
  - `{tag, src}` enter the shadow stage s1, then s2.
- **FIFO push:** the s2 entry (`ftoi` result + tag + src) is written when `s2_v`=1.
- **FIFO pop:** on `rsp_valid && rsp_ready`.
- Push and pop in the same cycle leave `count` unchanged.
- Overflow is impossible by credit; underflow is impossible by `rsp_valid` gating.
- **Conversion semantics** (from `ftoi`):
  - Round half away from zero.
  - Exponent < 126 gives 0.
  - Exponent > 157 gives 0 (including NaN/Inf).
- **Ordering:** results return strictly in acceptance order.
- **busy** = `s1_v | s2_v | (count != 0)`.
- **Reset:** asynchronous assertion clears s1/s2 valid bits, FIFO pointers, `count`, and `last` (set to 1).
  - `rsp_valid`=0, `busy`=0, both `ready`=0 while reset is asserted.
  - Stale `ftoi` output data is ignored; nothing is pushed until new accepts arrive.

## Timing
- Accept in cycle t:
  - s1 in t+1.
  - `ftoi` result and s2 in t+2.
  - Pushed at the end of t+2.
  - `rsp_valid` at t+3 when the FIFO was empty (fall-through disallowed).
- Throughput: 1 accept per cycle sustained when `rsp_ready`=1.
- With `rsp_ready`=0: exactly `FIFO_DEPTH` accepts, then both `ready`=0 until a pop.
  - Credit returns the cycle after the pop.
- All outputs except `reqN_ready` are registered or derive from registered FIFO state.

## Structure
- Shared package/header: `FTOI_LAT`=2, default `TAG_W`, and the `{data, tag, src}` entry width.
- Sub-module: one instance of `ftoi` (driven with the same `clk`; its `reset` input tied to `reset`).
- The arbiter, shadow pipeline, and FIFO are inline.

## Test plan
- **Single op:** `req0` 0x3FC00000, tag 5, `rsp_ready`=1 → `rsp_valid` at t+3 with data 0x00000002, tag 5, src 0; `busy` high t+1..t+3.
- **Contention:** both ports valid every cycle (port0 0x3F800000, port1 0xC0200000), `rsp_ready`=1 → grants 0,1,0,1…; responses alternate 0x00000001 / 0xFFFFFFFD, one per cycle.
- **Back-pressure:** `rsp_ready`=0, `req0` streaming → exactly 4 accepts, then `req0_ready`=0; when `rsp_ready`=1, the 4 results drain in order with no loss or duplication.
- **Push+pop same cycle:** `count`=3 with an s2 push and a pop together → `count` stays 3, head advances.
- **Mid-flight reset:** 2 in flight + 2 buffered, assert `reset` → `rsp_valid`/`busy` drop immediately; after release, no stale responses appear and the first accept goes to port 0.
- **Range edges:** 0x3E800000 → 0; 0x3F000000 → 1; 0x4F000000 → 0.
